// File: rtl/alu_sequencer.sv
// ALU request sequencer: walks one 8085 ALU-register opcode through
// operand load, ALU execute and completion, and holds the Z/P/CY flags.
// Outputs decode only from the state register and the latched request,
// so start/opcode never reach an output combinationally.
//
// state | meaning
// IDLE  | waiting for start; request latched on acceptance
// LOAD  | accumulator to ACT, data bus to ALU TMP
// EXEC  | ALU computes, result written to A (except CMP), flags captured
// DONE  | completion pulse; optional accumulator drive onto data bus
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       drive_result,
  input  logic       alu_zero,
  input  logic       alu_parity,
  input  logic       alu_carry,
  output logic       select_op1,
  output logic       select_op2,
  output logic       select_neg,
  output logic       select_ncarry_1,
  output logic       select_shift_right,
  output logic       shift_right_in,
  output logic       a_to_act,
  output logic       dbus_to_act,
  output logic       write_dbus_to_alu_tmp,
  output logic       alu_to_a,
  output logic       sel_alu_a,
  output logic       alu_a_to_dbus,
  output logic       sel_0_fe,
  output logic       fe_0_to_act,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       flag_z,
  output logic       flag_p,
  output logic       flag_cy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] CLS_ADD = 5'b10000;
  localparam logic [4:0] CLS_SUB = 5'b10010;
  localparam logic [4:0] CLS_XRA = 5'b10101;
  localparam logic [4:0] CLS_ORA = 5'b10110;
  localparam logic [4:0] CLS_CMP = 5'b10111;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic       drive_q, drive_d;
  logic       illegal_q, illegal_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_p_q, flag_p_d;
  logic       flag_cy_q, flag_cy_d;

  logic       legal_in;
  logic [4:0] cls_q;
  logic       unused_opcode_lsbs;

  assign cls_q              = opcode_q[7:3];
  assign unused_opcode_lsbs = ^opcode_q[2:0];
  assign legal_in = (opcode[7:3] == CLS_ADD) || (opcode[7:3] == CLS_SUB) ||
                    (opcode[7:3] == CLS_XRA) || (opcode[7:3] == CLS_ORA) ||
                    (opcode[7:3] == CLS_CMP);

  // State, latched request and flags; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 8'h00;
      drive_q   <= 1'b0;
      illegal_q <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_p_q  <= 1'b0;
      flag_cy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      drive_q   <= drive_d;
      illegal_q <= illegal_d;
      flag_z_q  <= flag_z_d;
      flag_p_q  <= flag_p_d;
      flag_cy_q <= flag_cy_d;
    end
  end

  // Next-state, request capture and flag update at the end of EXEC.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    drive_d   = drive_q;
    illegal_d = illegal_q;
    flag_z_d  = flag_z_q;
    flag_p_d  = flag_p_q;
    flag_cy_d = flag_cy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d  = opcode;
          drive_d   = drive_result;
          illegal_d = ~legal_in;
          state_d   = legal_in ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d  = ST_DONE;
        flag_z_d = alu_zero;
        flag_p_d = alu_parity;
        // The ALU reports an inverted carry for additions.
        if (cls_q == CLS_ADD)                             flag_cy_d = ~alu_carry;
        else if ((cls_q == CLS_SUB) || (cls_q == CLS_CMP)) flag_cy_d = alu_carry;
        else                                              flag_cy_d = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and ALU control decode from state and latched request only.
  always_comb begin
    select_op1            = 1'b0;
    select_op2            = 1'b0;
    select_neg            = 1'b0;
    select_ncarry_1       = 1'b0;
    a_to_act              = 1'b0;
    write_dbus_to_alu_tmp = 1'b0;
    alu_to_a              = 1'b0;
    sel_alu_a             = 1'b0;
    alu_a_to_dbus         = 1'b0;
    done                  = 1'b0;
    illegal               = 1'b0;
    case (state_q)
      ST_LOAD: begin
        a_to_act              = 1'b1;
        write_dbus_to_alu_tmp = 1'b1;
      end
      ST_EXEC: begin
        sel_alu_a = 1'b1;
        alu_to_a  = (cls_q != CLS_CMP);
        case (cls_q)
          CLS_ADD: select_op1 = 1'b1;
          CLS_SUB, CLS_CMP: begin
            select_op1 = 1'b1;
            select_neg = 1'b1;
          end
          CLS_XRA: begin
            select_op1      = 1'b1;
            select_ncarry_1 = 1'b1;
          end
          CLS_ORA: select_ncarry_1 = 1'b1;
          default: ;
        endcase
      end
      ST_DONE: begin
        done          = 1'b1;
        illegal       = illegal_q;
        alu_a_to_dbus = drive_q & ~illegal_q;
      end
      default: ;
    endcase
  end

  assign busy               = (state_q != ST_IDLE);
  assign select_shift_right = 1'b0;
  assign shift_right_in     = 1'b0;
  assign dbus_to_act        = 1'b0;
  assign sel_0_fe           = 1'b0;
  assign fe_0_to_act        = 1'b0;
  assign flag_z             = flag_z_q;
  assign flag_p             = flag_p_q;
  assign flag_cy            = flag_cy_q;

endmodule
